// File: rtl/operand_fetch.sv
// Operand fetch: drives the register file read ports for one issue bundle per cycle,
// forwards same-edge writebacks, and buffers the operands in a 2-entry output FIFO.
`timescale 1ns/1ps

`ifndef PARALLEL_ORDER
`define PARALLEL_ORDER 2
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module operand_fetch #(
  parameter int P  = `PARALLEL_ORDER,
  parameter int AW = `REG_ADDR_WIDTH,
  parameter int DW = `REG_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P-1:0]         in_lane_en,
  input  logic [P-1:0][AW-1:0] in_src1,
  input  logic [P-1:0][AW-1:0] in_src2,
  output logic [P-1:0]         r_valid1,
  output logic [P-1:0][AW-1:0] r_addr1,
  output logic [P-1:0]         r_valid2,
  output logic [P-1:0][AW-1:0] r_addr2,
  input  logic [P-1:0][DW-1:0] r_data1,
  input  logic [P-1:0][DW-1:0] r_data2,
  input  logic [P-1:0]         w_valid,
  input  logic [P-1:0][AW-1:0] w_addr,
  input  logic [P-1:0][DW-1:0] w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P-1:0]         out_lane_en,
  output logic [P-1:0][DW-1:0] out_op1,
  output logic [P-1:0][DW-1:0] out_op2
);

  // Returns {hit, data}; later write lanes override earlier ones.
  function automatic logic [DW:0] fwd_lookup(
    input logic [AW-1:0]         src,
    input logic [P-1:0]          wv,
    input logic [P-1:0][AW-1:0]  wa,
    input logic [P-1:0][DW-1:0]  wd
  );
    logic [DW:0] res;
    res = '0;
    for (int j = 0; j < P; j++) begin
      if (wv[j] && (wa[j] == src)) res = {1'b1, wd[j]};
    end
    return res;
  endfunction

  logic                 accept;
  logic                 pop;
  logic [1:0]           cnt;
  logic [P-1:0][DW:0]   look1_p0, look2_p0;

  logic                 vld_p1;
  logic [P-1:0]         lane_en_p1, hit1_p1, hit2_p1;
  logic [P-1:0][DW-1:0] fwd1_p1, fwd2_p1;

  logic [P-1:0][DW-1:0] op1_p2, op2_p2;
  logic [P-1:0]         fifo_en  [2];
  logic [P-1:0][DW-1:0] fifo_op1 [2];
  logic [P-1:0][DW-1:0] fifo_op2 [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           fifo_cnt;

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (cnt < 2'd2) || pop;
  // Gated by rst_n so no read is issued while reset is held.
  assign accept    = rst_n && in_valid && in_ready;

  // Stage p0: read port drive and writeback snoop at the accept edge
  always_comb begin
    r_valid1 = '0;
    r_valid2 = '0;
    r_addr1  = '0;
    r_addr2  = '0;
    look1_p0 = '0;
    look2_p0 = '0;
    for (int i = 0; i < P; i++) begin
      r_valid1[i] = accept && in_lane_en[i];
      r_valid2[i] = accept && in_lane_en[i];
      r_addr1[i]  = accept ? in_src1[i] : '0;
      r_addr2[i]  = accept ? in_src2[i] : '0;
      look1_p0[i] = fwd_lookup(in_src1[i], w_valid, w_addr, w_data);
      look2_p0[i] = fwd_lookup(in_src2[i], w_valid, w_addr, w_data);
    end
  end

  // Stage p1: in-flight bundle waiting for the register file data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lane_en_p1 <= in_lane_en;
      for (int i = 0; i < P; i++) begin
        hit1_p1[i] <= look1_p0[i][DW];
        hit2_p1[i] <= look2_p0[i][DW];
        fwd1_p1[i] <= look1_p0[i][DW-1:0];
        fwd2_p1[i] <= look2_p0[i][DW-1:0];
      end
    end
  end

  // Stage p2: operand select and FIFO write
  always_comb begin
    op1_p2 = '0;
    op2_p2 = '0;
    for (int i = 0; i < P; i++) begin
      if (lane_en_p1[i]) begin
        op1_p2[i] = hit1_p1[i] ? fwd1_p1[i] : r_data1[i];
        op2_p2[i] = hit2_p1[i] ? fwd2_p1[i] : r_data2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      fifo_en[wr_ptr]  <= lane_en_p1;
      fifo_op1[wr_ptr] <= op1_p2;
      fifo_op2[wr_ptr] <= op2_p2;
    end
  end

  // The credit counter covers the in-flight stage too, so the FIFO cannot overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      fifo_cnt <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
      case ({vld_p1, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
    end
  end

  assign out_lane_en = out_valid ? fifo_en[rd_ptr]  : '0;
  assign out_op1     = out_valid ? fifo_op1[rd_ptr] : '0;
  assign out_op2     = out_valid ? fifo_op2[rd_ptr] : '0;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file on the read ports.
`timescale 1ns/1ps

module tb_operand_fetch;
  localparam int P  = 2;
  localparam int AW = 5;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [P-1:0]         in_lane_en;
  logic [P-1:0][AW-1:0] in_src1, in_src2;
  logic [P-1:0]         r_valid1, r_valid2;
  logic [P-1:0][AW-1:0] r_addr1, r_addr2;
  logic [P-1:0][DW-1:0] r_data1, r_data2;
  logic [P-1:0]         w_valid;
  logic [P-1:0][AW-1:0] w_addr;
  logic [P-1:0][DW-1:0] w_data;
  logic                 out_valid, out_ready;
  logic [P-1:0]         out_lane_en;
  logic [P-1:0][DW-1:0] out_op1, out_op2;

  logic [DW-1:0] regs [32];
  int errors = 0;
  int checks = 0;

  operand_fetch #(.P(P), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_en(in_lane_en),
    .in_src1(in_src1), .in_src2(in_src2),
    .r_valid1(r_valid1), .r_addr1(r_addr1), .r_valid2(r_valid2), .r_addr2(r_addr2),
    .r_data1(r_data1), .r_data2(r_data2),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_en(out_lane_en),
    .out_op1(out_op1), .out_op2(out_op2)
  );

  always #5 clk = ~clk;

  // Register file: reads return pre-edge contents; highest write lane wins.
  always @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (r_valid1[i]) r_data1[i] <= regs[r_addr1[i]];
      if (r_valid2[i]) r_data2[i] <= regs[r_addr2[i]];
    end
    for (int j = 0; j < P; j++) begin
      if (w_valid[j]) regs[w_addr[j]] <= w_data[j];
    end
  end

  function automatic logic [DW-1:0] pre(input int a);
    int v;
    v = 32 + a;
    return v[DW-1:0];
  endfunction

  function automatic logic [P-1:0] b_en(input int k);
    int m;
    m = k % 3 + 1;
    return m[P-1:0];
  endfunction

  function automatic int b_addr(input int k, input int i, input int port);
    return (port == 1) ? (k * 2 + i + 4) : (k * 2 + i + 12);
  endfunction

  function automatic logic [DW-1:0] exp_op(input int k, input int i, input int port);
    logic [P-1:0] en;
    en = b_en(k);
    return en[i] ? pre(b_addr(k, i, port)) : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_lane_en = '0; in_src1 = '0; in_src2 = '0;
    w_valid = '0; w_addr = '0; w_data = '0;
  endtask

  task automatic drive_bundle(input int k);
    int a;
    in_valid = 1'b1;
    in_lane_en = b_en(k);
    for (int i = 0; i < P; i++) begin
      a = b_addr(k, i, 1); in_src1[i] = a[AW-1:0];
      a = b_addr(k, i, 2); in_src2[i] = a[AW-1:0];
    end
  endtask

  task automatic preload();
    int a;
    for (int b = 0; b < 32; b += 2) begin
      w_valid = 2'b11;
      a = b;     w_addr[0] = a[AW-1:0]; w_data[0] = pre(a);
      a = b + 1; w_addr[1] = a[AW-1:0]; w_data[1] = pre(a);
      step();
    end
    w_valid = 2'b11;
    w_addr[0] = 5'd1; w_data[0] = 8'd4;
    w_addr[1] = 5'd2; w_data[1] = 8'd5;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] rnd;
    rst_n = 1'b0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      rnd = $urandom; in_valid = rnd[0]; out_ready = rnd[1]; in_lane_en = rnd[3:2];
      rnd = $urandom; in_src1 = rnd[P*AW-1:0];
      rnd = $urandom; in_src2 = rnd[P*AW-1:0];
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
      checks++; if (r_valid1 !== 2'b00) begin errors++; $display("FAIL rst_r_valid1 got=%0h exp=0", r_valid1); end
      checks++; if (r_valid2 !== 2'b00) begin errors++; $display("FAIL rst_r_valid2 got=%0h exp=0", r_valid2); end
      checks++; if (out_op1 !== '0) begin errors++; $display("FAIL rst_out_op1 got=%0h exp=0", out_op1); end
      step();
    end
    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic_read();
    out_ready = 1'b1;
    in_valid = 1'b1; in_lane_en = 2'b10;
    in_src1[1] = 5'd1; in_src2[1] = 5'd2; in_src1[0] = 5'd0; in_src2[0] = 5'd0;
    #1;
    checks++; if (r_valid1 !== 2'b10) begin errors++; $display("FAIL basic_r_valid1 got=%0h exp=2", r_valid1); end
    checks++; if (r_valid2 !== 2'b10) begin errors++; $display("FAIL basic_r_valid2 got=%0h exp=2", r_valid2); end
    checks++; if (r_addr1[1] !== 5'd1) begin errors++; $display("FAIL basic_r_addr1 got=%0h exp=1", r_addr1[1]); end
    checks++; if (r_addr2[1] !== 5'd2) begin errors++; $display("FAIL basic_r_addr2 got=%0h exp=2", r_addr2[1]); end
    step();
    idle_inputs();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%0h exp=0", out_valid); end
    checks++; if (r_addr1 !== '0) begin errors++; $display("FAIL basic_idle_addr got=%0h exp=0", r_addr1); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
    checks++; if (out_lane_en !== 2'b10) begin errors++; $display("FAIL basic_lane_en got=%0h exp=2", out_lane_en); end
    checks++; if (out_op1[1] !== 8'd4) begin errors++; $display("FAIL basic_op1 got=%0h exp=4", out_op1[1]); end
    checks++; if (out_op2[1] !== 8'd5) begin errors++; $display("FAIL basic_op2 got=%0h exp=5", out_op2[1]); end
    checks++; if (out_op1[0] !== 8'd0 || out_op2[0] !== 8'd0) begin errors++; $display("FAIL basic_lane0 got=%0h/%0h exp=0/0", out_op1[0], out_op2[0]); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_forward();
    out_ready = 1'b1;
    // reg3 holds 0x23; the same-edge write of 9 must be forwarded
    in_valid = 1'b1; in_lane_en = 2'b01; in_src1[0] = 5'd3; in_src2[0] = 5'd1;
    w_valid = 2'b01; w_addr[0] = 5'd3; w_data[0] = 8'd9;
    step();
    idle_inputs();
    step();
    checks++; if (out_op1[0] !== 8'd9) begin errors++; $display("FAIL fwd1_op1 got=%0h exp=9", out_op1[0]); end
    checks++; if (out_op2[0] !== 8'd4) begin errors++; $display("FAIL fwd1_op2 got=%0h exp=4", out_op2[0]); end
    checks++; if (out_op1[1] !== 8'd0) begin errors++; $display("FAIL fwd1_lane1 got=%0h exp=0", out_op1[1]); end
    checks++; if (out_lane_en !== 2'b01) begin errors++; $display("FAIL fwd1_lane_en got=%0h exp=1", out_lane_en); end
    step();
    // two write lanes hit reg3: lane 1 (data 8) wins; a later write to reg1 must not leak in
    in_valid = 1'b1; in_lane_en = 2'b01; in_src1[0] = 5'd3; in_src2[0] = 5'd1;
    w_valid = 2'b11; w_addr[0] = 5'd3; w_data[0] = 8'd7; w_addr[1] = 5'd3; w_data[1] = 8'd8;
    step();
    idle_inputs();
    w_valid = 2'b01; w_addr[0] = 5'd1; w_data[0] = 8'h66;
    step();
    idle_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fwd2_valid got=%0h exp=1", out_valid); end
    checks++; if (out_op1[0] !== 8'd8) begin errors++; $display("FAIL fwd2_op1 got=%0h exp=8", out_op1[0]); end
    checks++; if (out_op2[0] !== 8'd4) begin errors++; $display("FAIL fwd2_snapshot got=%0h exp=4", out_op2[0]); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive_bundle(0); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_a got=%0h exp=1", in_ready); end
    step();
    drive_bundle(1); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_b got=%0h exp=1", in_ready); end
    step();
    drive_bundle(2); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c got=%0h exp=0", in_ready); end
    checks++; if (r_valid1 !== 2'b00) begin errors++; $display("FAIL bp_r_valid_c got=%0h exp=0", r_valid1); end
    checks++; if (r_addr1 !== '0) begin errors++; $display("FAIL bp_r_addr_c got=%0h exp=0", r_addr1); end
    step();
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got=%0h exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold got=%0h exp=1", out_valid); end
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) idle_inputs();
      #1;
      if (k == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_pop got=%0h exp=1", in_ready); end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%0h exp=1", k, out_valid); end
      checks++; if (out_lane_en !== b_en(k)) begin errors++; $display("FAIL bp_lane_en[%0d] got=%0h exp=%0h", k, out_lane_en, b_en(k)); end
      for (int i = 0; i < P; i++) begin
        checks++; if (out_op1[i] !== exp_op(k, i, 1)) begin errors++; $display("FAIL bp_op1[%0d][%0d] got=%0h exp=%0h", k, i, out_op1[i], exp_op(k, i, 1)); end
        checks++; if (out_op2[i] !== exp_op(k, i, 2)) begin errors++; $display("FAIL bp_op2[%0d][%0d] got=%0h exp=%0h", k, i, out_op2[i], exp_op(k, i, 2)); end
      end
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0h exp=0", out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive_bundle(c);
      else idle_inputs();
      #1;
      if (c < 8) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", c, in_ready); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", c, out_valid); end
        checks++; if (out_lane_en !== b_en(c - 2)) begin errors++; $display("FAIL b2b_lane_en[%0d] got=%0h exp=%0h", c, out_lane_en, b_en(c - 2)); end
        for (int i = 0; i < P; i++) begin
          checks++; if (out_op1[i] !== exp_op(c - 2, i, 1)) begin errors++; $display("FAIL b2b_op1[%0d][%0d] got=%0h exp=%0h", c, i, out_op1[i], exp_op(c - 2, i, 1)); end
          checks++; if (out_op2[i] !== exp_op(c - 2, i, 2)) begin errors++; $display("FAIL b2b_op2[%0d][%0d] got=%0h exp=%0h", c, i, out_op2[i], exp_op(c - 2, i, 2)); end
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got=%0h exp=0", c, out_valid); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_bundle(3); step();
    drive_bundle(4); step();
    idle_inputs(); step();
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got=%0h/%0h exp=1/0", out_valid, in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid got=%0h exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_async_ready got=%0h exp=1", in_ready); end
    checks++; if (out_lane_en !== 2'b00 || out_op1 !== '0) begin errors++; $display("FAIL mid_async_data got=%0h/%0h exp=0/0", out_lane_en, out_op1); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d] got=%0h exp=0", c, out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready[%0d] got=%0h exp=1", c, in_ready); end
      step();
    end
    drive_bundle(5); step();
    idle_inputs(); step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got=%0h exp=1", out_valid); end
    for (int i = 0; i < P; i++) begin
      checks++; if (out_op1[i] !== exp_op(5, i, 1)) begin errors++; $display("FAIL mid_new_op1[%0d] got=%0h exp=%0h", i, out_op1[i], exp_op(5, i, 1)); end
      checks++; if (out_op2[i] !== exp_op(5, i, 2)) begin errors++; $display("FAIL mid_new_op2[%0d] got=%0h exp=%0h", i, out_op2[i], exp_op(5, i, 2)); end
    end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_new_drain got=%0h exp=0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle_inputs();
    step();
    test_reset();
    preload();
    test_basic_read();
    test_forward();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
